// File: rtl/rename_stage.sv
// rename_stage: single-issue register rename using a speculative map, a committed map and a circular free list
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2,
  input  logic [$clog2(ARCH_REGS)-1:0] rd,
  input  logic                         rd_we,
  input  logic [PAYLOAD_W-1:0]         payload_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [$clog2(PHYS_REGS)-1:0] prs1,
  output logic [$clog2(PHYS_REGS)-1:0] prs2,
  output logic [$clog2(PHYS_REGS)-1:0] prd,
  output logic [$clog2(PHYS_REGS)-1:0] old_prd,
  output logic                         rd_we_out,
  output logic [PAYLOAD_W-1:0]         payload_out,
  input  logic                         commit_valid,
  input  logic                         commit_rd_we,
  input  logic [$clog2(ARCH_REGS)-1:0] commit_rd,
  input  logic [$clog2(PHYS_REGS)-1:0] commit_prd,
  input  logic [$clog2(PHYS_REGS)-1:0] commit_old_prd,
  input  logic                         flush
);
  localparam int AW    = $clog2(ARCH_REGS);
  localparam int PW    = $clog2(PHYS_REGS);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int DW    = $clog2(DEPTH);
  localparam int PTRW  = DW + 1;
  localparam logic [PTRW-1:0] P_ONE = PTRW'(1);
  logic [PW-1:0]   r_spec_map   [ARCH_REGS];
  logic [PW-1:0]   r_commit_map [ARCH_REGS];
  logic [PW-1:0]   r_fl         [DEPTH];
  logic [PTRW-1:0] r_head, r_tail, r_commit_head;
  logic            w_need_alloc, w_empty, w_fire, w_alloc, w_commit;
  logic [PTRW-1:0] w_commit_head_nxt;
  logic [PW-1:0]   w_alloc_tag;
  assign w_need_alloc      = rd_we && rd != '0;
  assign w_empty           = r_tail == r_head;
  assign ready_in          = !flush && (!valid_out || ready_out) && !(w_need_alloc && w_empty);
  assign w_fire            = valid_in && ready_in;
  assign w_alloc           = w_fire && w_need_alloc;
  assign w_commit          = commit_valid && commit_rd_we && commit_rd != '0;
  assign w_commit_head_nxt = w_commit ? r_commit_head + P_ONE : r_commit_head;
  assign w_alloc_tag       = r_fl[r_head[DW-1:0]];
  // free list storage and the head/tail/commit-head pointers; flush rewinds head to the retired point
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_fl[i] <= PW'(ARCH_REGS + i);
      r_head        <= '0;
      r_tail        <= PTRW'(DEPTH);
      r_commit_head <= '0;
    end else begin
      if (w_commit) begin
        r_fl[r_tail[DW-1:0]] <= commit_old_prd;
        r_tail               <= r_tail + P_ONE;
      end
      r_commit_head <= w_commit_head_nxt;
      if (flush) r_head <= w_commit_head_nxt;
      else if (w_alloc) r_head <= r_head + P_ONE;
    end
  end
  // committed and speculative maps; flush copies the committed map including this cycle's retirement
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec_map[i]   <= PW'(i);
        r_commit_map[i] <= PW'(i);
      end
    end else begin
      if (w_commit) r_commit_map[commit_rd] <= commit_prd;
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++)
          r_spec_map[i] <= (w_commit && commit_rd == AW'(i)) ? commit_prd : r_commit_map[i];
      end else if (w_alloc) r_spec_map[rd] <= w_alloc_tag;
    end
  end
  // registered output stage: load on fire, hold while stalled, drop valid when drained or flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out   <= 1'b0;
      prs1        <= '0;
      prs2        <= '0;
      prd         <= '0;
      old_prd     <= '0;
      rd_we_out   <= 1'b0;
      payload_out <= '0;
    end else if (flush) valid_out <= 1'b0;
    else if (w_fire) begin
      valid_out   <= 1'b1;
      prs1        <= r_spec_map[rs1];
      prs2        <= r_spec_map[rs2];
      prd         <= w_need_alloc ? w_alloc_tag : '0;
      old_prd     <= w_need_alloc ? r_spec_map[rd] : '0;
      rd_we_out   <= rd_we;
      payload_out <= payload_in;
    end else if (ready_out) valid_out <= 1'b0;
  end
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed self-checking bench for rename_stage
module tb_rename_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        valid_in, ready_in, rd_we, valid_out, ready_out, rd_we_out;
  logic [4:0]  rs1, rs2, rd, commit_rd;
  logic [5:0]  prs1, prs2, prd, old_prd, commit_prd, commit_old_prd;
  logic [63:0] payload_in, payload_out;
  logic        commit_valid, commit_rd_we, flush;
  int          vectors = 0, miscompares = 0, n;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .payload_in(payload_in),
    .valid_out(valid_out), .ready_out(ready_out), .prs1(prs1), .prs2(prs2),
    .prd(prd), .old_prd(old_prd), .rd_we_out(rd_we_out), .payload_out(payload_out),
    .commit_valid(commit_valid), .commit_rd_we(commit_rd_we), .commit_rd(commit_rd),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd), .flush(flush)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int p1, input int p2, input int pd, input int op);
    chk({tag, "_valid"}, valid_out, 1);
    chk({tag, "_prs1"}, prs1, p1);
    chk({tag, "_prs2"}, prs2, p2);
    chk({tag, "_prd"}, prd, pd);
    chk({tag, "_old"}, old_prd, op);
  endtask

  task automatic ren(input int r1, input int r2, input int d, input logic we);
    valid_in   = 1'b1;
    rs1        = 5'(r1);
    rs2        = 5'(r2);
    rd         = 5'(d);
    rd_we      = we;
    payload_in = {32'hCAFE0000, 32'(d)};
  endtask

  task automatic cmt(input int r, input int p, input int o);
    commit_valid   = 1'b1;
    commit_rd_we   = 1'b1;
    commit_rd      = 5'(r);
    commit_prd     = 6'(p);
    commit_old_prd = 6'(o);
  endtask

  initial begin
    valid_in = 0; rs1 = 0; rs2 = 0; rd = 0; rd_we = 0; payload_in = 0; ready_out = 1;
    commit_valid = 0; commit_rd_we = 0; commit_rd = 0; commit_prd = 0; commit_old_prd = 0; flush = 0;
    tick; tick;
    reset = 0;
    chk("rst_valid", valid_out, 0);
    chk("rst_prd", prd, 0);
    chk("rst_payload", payload_out, 0);
    chk("rst_ready", ready_in, 1);
    // basic rename and back-to-back dependency
    ren(1, 2, 5, 1); tick;
    chk_out("add_x5", 1, 2, 32, 5);
    chk("payload", payload_out, {32'hCAFE0000, 32'd5});
    chk("rd_we_out", rd_we_out, 1);
    ren(5, 5, 6, 1); tick;
    chk_out("add_x6", 32, 32, 33, 6);
    ren(0, 0, 0, 1); tick;
    chk_out("rd_x0", 0, 0, 0, 0);
    ren(7, 3, 7, 1); tick;
    chk_out("rs1_eq_rd", 7, 3, 34, 7);
    // drain the free list
    for (int k = 0; k < 29; k++) begin ren(1, 2, 9, 1); tick; end
    chk_out("last_free", 1, 2, 63, 62);
    ren(1, 2, 10, 1);
    rd_we = 0; #1 chk("nonalloc_ready", ready_in, 1);
    rd_we = 1; #1 chk("empty_stall", ready_in, 0);
    cmt(5, 32, 5); #1 chk("no_bypass", ready_in, 0);
    tick;
    commit_valid = 0;
    chk("valid_clear", valid_out, 0);
    chk("ready_after_free", ready_in, 1);
    tick;
    chk_out("wrap", 1, 2, 5, 10);
    valid_in = 0;
    // in-order commits, including one to x0 that must change nothing
    cmt(6, 33, 6); tick;
    cmt(0, 0, 17); tick;
    cmt(7, 34, 7); tick;
    commit_valid = 0;
    // downstream backpressure
    ready_out = 0;
    ren(1, 1, 11, 1); tick;
    chk_out("hold_a", 1, 1, 6, 11);
    ren(2, 11, 12, 1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_ready", ready_in, 0);
      tick;
      chk_out("hold_stable", 1, 1, 6, 11);
    end
    ready_out = 1;
    #1 chk("release_ready", ready_in, 1);
    tick;
    chk_out("rel_b", 2, 6, 7, 12);
    ren(11, 12, 13, 0); tick;
    chk_out("rel_c", 6, 7, 0, 0);
    chk("rel_c_we", rd_we_out, 0);
    // reset mid-operation
    reset = 1; valid_in = 0; tick;
    reset = 0;
    chk("midrst_valid", valid_out, 0);
    // flush restores committed state
    ren(0, 0, 3, 1); tick;
    chk_out("fx3", 0, 0, 32, 3);
    ren(0, 0, 4, 1); tick;
    chk_out("fx4", 0, 0, 33, 4);
    valid_in = 0;
    cmt(3, 32, 3); tick;
    commit_valid = 0; flush = 1;
    #1 chk("flush_ready", ready_in, 0);
    tick;
    flush = 0;
    chk("flush_valid", valid_out, 0);
    ren(3, 4, 9, 1); tick;
    chk_out("post_flush", 32, 4, 33, 9);
    // flush coinciding with a commit
    for (int k = 0; k < 6; k++) begin ren(0, 0, 10, 1); tick; end
    ren(0, 0, 8, 1); tick;
    chk_out("x8", 0, 0, 40, 8);
    valid_in = 0;
    cmt(9, 33, 9); tick;
    cmt(10, 34, 10); tick;
    for (int k = 0; k < 5; k++) begin cmt(10, 35 + k, 34 + k); tick; end
    cmt(8, 40, 8); flush = 1; ren(5, 5, 5, 1);
    tick;
    commit_valid = 0; flush = 0; valid_in = 0;
    chk("fc_valid", valid_out, 0);
    ren(8, 10, 8, 1); tick;
    chk_out("fc_map", 40, 39, 41, 40);
    // remaining free count reflects the tail advance in the flush cycle
    ren(1, 1, 11, 1);
    n = 0;
    #1;
    for (int k = 0; k < 40 && ready_in; k++) begin tick; n++; end
    chk("free_count", n, 31);
    valid_in = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
